// File: rtl/xpar_bridge_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : xpar_bridge_pkg                                               |
// | Purpose  : Shared definitions for the external parallel-port bridge:     |
// |            FSM state encoding (3-bit), timeout read-data fill value and  |
// |            default wait/timeout parameter values.                        |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package xpar_bridge_pkg;

  // Bridge sequencer states. The encoding is fixed so that waveforms and
  // debug probes read the same across builds.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } xb_state_e;

  // A timed-out read returns every data bit set to this value, so software
  // sees an unmistakable all-ones word.
  localparam logic XB_TIMEOUT_RDATA_BIT = 1'b1;

  // Default handshake timing.
  localparam int XB_WAIT_MIN_DEF = 0;
  localparam int XB_TIMEOUT_DEF  = 255;
  localparam int XB_CNT_W_DEF    = 8;

endpackage : xpar_bridge_pkg
`default_nettype wire

// File: rtl/xpar_bridge_xwait_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : xwait_cnt                                                     |
// | Purpose  : Wait-state / timeout counter for the parallel-port bridge.    |
// |            Counts REQ cycles and flags when the minimum wait has been    |
// |            served and when the last permitted REQ cycle is reached.      |
// | Ports    : clk, rst     - clock, async active-high reset                 |
// |            clr_i        - synchronous clear (priority over enable)       |
// |            en_i         - increment enable                               |
// |            ge_min_o     - count >= WAIT_MIN                              |
// |            expired_o    - count == TIMEOUT-1 (last REQ cycle)            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module xwait_cnt #(
  parameter int CNT_W    = 8,
  parameter int WAIT_MIN = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic ge_min_o,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + C_ONE;
    end
  end

  // With no minimum wait the compare is trivially true; tie it off rather
  // than building an always-true unsigned comparison.
  generate
    if (WAIT_MIN == 0) begin : g_min_zero
      assign ge_min_o = 1'b1;
    end else begin : g_min_cmp
      localparam logic [CNT_W-1:0] C_WAIT_MIN = CNT_W'(WAIT_MIN);
      assign ge_min_o = (cnt_q >= C_WAIT_MIN);
    end
  endgenerate

  assign expired_o = (cnt_q == C_LAST);

endmodule : xwait_cnt
`default_nettype wire

// File: rtl/xpar_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : xpar_bridge                                                   |
// | Purpose  : Bridge from the single-cycle controller data bus to an        |
// |            external parallel device using a 4-phase req/ack handshake,   |
// |            programmable minimum wait states, a REQ timeout with sticky   |
// |            error flag, and a stall output holding the controller.        |
// | Ports    : clk, rst          - clock, async active-high reset            |
// |            sel, we, addr     - access request from the address decoder   |
// |            data_in/data_out  - write data in / registered read data out  |
// |            stall             - hold controller while high                |
// |            err, err_clr      - sticky timeout flag and its clear         |
// |            par_addr/par_out  - registered external address / write data  |
// |            par_in            - external read data                        |
// |            par_req/par_ack   - handshake pair                            |
// |            par_we            - registered write qualifier                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module xpar_bridge
  import xpar_bridge_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int WAIT_MIN = XB_WAIT_MIN_DEF,
  parameter int TIMEOUT  = XB_TIMEOUT_DEF,
  parameter int CNT_W    = XB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              err,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] par_addr,
  output logic [DATA_W-1:0] par_out,
  input  logic [DATA_W-1:0] par_in,
  output logic              par_req,
  output logic              par_we,
  input  logic              par_ack
);

  xb_state_e         state_q;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] par_addr_q;
  logic [DATA_W-1:0] par_out_q;
  logic              par_req_q;
  logic              par_we_q;
  logic              err_q;
  logic              err_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_ge_min;
  logic              cnt_expired;
  logic              ack_ok;
  logic              tmo_hit;
  logic              stall_c;

  // The counter is zeroed while SETUP is active so that the first REQ cycle
  // observes a count of zero, and advances once per REQ cycle.
  assign cnt_clr = (state_q == ST_SETUP);
  assign cnt_en  = (state_q == ST_REQ);

  xwait_cnt #(
    .CNT_W    (CNT_W),
    .WAIT_MIN (WAIT_MIN),
    .TIMEOUT  (TIMEOUT)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .ge_min_o  (cnt_ge_min),
    .expired_o (cnt_expired)
  );

  // An ack is only honoured once the minimum wait has been served. A timeout
  // fires on the last allowed REQ cycle when that cycle did not accept.
  assign ack_ok  = (state_q == ST_REQ) && par_ack && cnt_ge_min;
  assign tmo_hit = (state_q == ST_REQ) && !ack_ok && cnt_expired;

  // Sticky error: a timeout in the same cycle as a clear must still set it.
  always_comb begin
    err_d = err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      par_addr_q <= '0;
      par_out_q  <= '0;
      par_req_q  <= 1'b0;
      par_we_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          // The external address/data/we only move here, so the device sees
          // stable values for the whole handshake and after it.
          if (sel) begin
            par_addr_q <= addr;
            par_out_q  <= data_in;
            par_we_q   <= we;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          par_req_q <= 1'b1;
          state_q   <= ST_REQ;
        end
        ST_REQ: begin
          if (ack_ok) begin
            if (!par_we_q) begin
              data_out_q <= par_in;
            end
            par_req_q <= 1'b0;
            state_q   <= ST_RELEASE;
          end else if (cnt_expired) begin
            if (!par_we_q) begin
              data_out_q <= {DATA_W{XB_TIMEOUT_RDATA_BIT}};
            end
            par_req_q <= 1'b0;
            // The device never responded, so there is no ack to wait out.
            state_q   <= ST_DONE;
          end
        end
        ST_RELEASE: begin
          if (!par_ack) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // One-cycle window for the controller to finish; sel is not looked
          // at here so a held sel cannot restart the same access.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // stall must react in the same cycle sel arrives, so it is decoded
  // combinationally from the state rather than registered.
  always_comb begin
    stall_c = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:    stall_c = sel;
        ST_SETUP:   stall_c = 1'b1;
        ST_REQ:     stall_c = 1'b1;
        ST_RELEASE: stall_c = 1'b1;
        default:    stall_c = 1'b0;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign stall    = stall_c;
  assign err      = err_q;
  assign par_addr = par_addr_q;
  assign par_out  = par_out_q;
  assign par_req  = par_req_q;
  assign par_we   = par_we_q;

endmodule : xpar_bridge
`default_nettype wire

// File: tb/tb_xpar_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_xpar_bridge                                                |
// | Purpose  : Self-checking bench for xpar_bridge. Acts as the external     |
// |            device (ack timed relative to the start of the access) and    |
// |            predicts each access outcome from the handshake rules.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_xpar_bridge;

  localparam int WMIN = 2;
  localparam int TMO  = 8;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [10:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        stall;
  logic        err;
  logic        err_clr;
  logic [10:0] par_addr;
  logic [31:0] par_out;
  logic [31:0] par_in;
  logic        par_req;
  logic        par_we;
  logic        par_ack;

  int vecs = 0;
  int errs = 0;

  // Reference state carried between accesses.
  logic [10:0] prev_addr;
  logic [31:0] data_model;
  logic        err_model;

  xpar_bridge #(
    .DATA_W   (32),
    .ADDR_W   (11),
    .WAIT_MIN (WMIN),
    .TIMEOUT  (TMO),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .stall    (stall),
    .err      (err),
    .err_clr  (err_clr),
    .par_addr (par_addr),
    .par_out  (par_out),
    .par_in   (par_in),
    .par_req  (par_req),
    .par_we   (par_we),
    .par_ack  (par_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access. The device raises ack on REQ-relative cycles
  // [rise, fall) counted from the cycle two after sel. The outcome is
  // predicted from the rules: accept at max(rise, WMIN) if ack is still up
  // and that is before TMO, otherwise time out after TMO REQ cycles.
  task automatic run_access(input string name, input logic w, input logic [10:0] a,
                            input logic [31:0] d, input logic [31:0] pin,
                            input int rise, input int fall, input int clr_cycle);
    int          acc;
    int          rel;
    int          exp_req;
    int          exp_done;
    int          req_cnt;
    int          done_c;
    bit          tmo;
    bit          dn_sel;
    logic [31:0] exp_data;
    logic        exp_err;

    acc = (rise > WMIN) ? rise : WMIN;
    tmo = (acc >= fall) || (acc > TMO - 1);
    if (tmo) begin
      exp_req  = TMO;
      exp_done = TMO + 2;
    end else begin
      exp_req  = acc + 1;
      rel      = (acc + 1 > fall) ? acc + 1 : fall;
      exp_done = rel + 3;
    end
    exp_data = w ? data_model : (tmo ? 32'hFFFF_FFFF : pin);
    if (tmo)                                   exp_err = 1'b1;
    else if (clr_cycle >= 0 && clr_cycle < exp_done) exp_err = 1'b0;
    else                                       exp_err = err_model;
    dn_sel  = 1'($urandom_range(0, 1));
    req_cnt = 0;
    done_c  = -1;

    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      sel     = (c == 0) || (c == exp_done && dn_sel);
      we      = (c == 0) ? w : 1'($urandom_range(0, 1));
      addr    = (c == 0) ? a : 11'($urandom);
      data_in = (c == 0) ? d : $urandom;
      par_in  = (!tmo && c == acc + 2) ? pin : $urandom;
      par_ack = (c - 2 >= rise) && (c - 2 < fall);
      err_clr = (c == clr_cycle);
      @(negedge clk);
      if (c == 0) begin
        chk({name, " stall_on_sel"}, {31'b0, stall}, 32'd1);
        chk({name, " addr_hold_idle"}, {21'b0, par_addr}, {21'b0, prev_addr});
      end
      if (c == 1) chk({name, " setup_req_low"}, {31'b0, par_req}, 32'd0);
      if (par_req) req_cnt++;
      if (c > 0 && !stall) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end

    chk({name, " stall_release_cycle"}, 32'(done_c), 32'(exp_done));
    chk({name, " req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({name, " par_addr"}, {21'b0, par_addr}, {21'b0, a});
    chk({name, " par_out"}, par_out, d);
    chk({name, " par_we"}, {31'b0, par_we}, {31'b0, w});
    chk({name, " data_out"}, data_out, exp_data);
    chk({name, " err"}, {31'b0, err}, {31'b0, exp_err});

    prev_addr  = a;
    data_model = exp_data;
    err_model  = exp_err;
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b1;
    we      = 1'b0;
    addr    = '0;
    data_in = '0;
    err_clr = 1'b0;
    par_in  = '0;
    par_ack = 1'b0;
    prev_addr  = '0;
    data_model = '0;
    err_model  = 1'b0;

    // Reset state, with sel high to show stall is forced low under reset.
    #3;
    chk("rst stall", {31'b0, stall}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst par_addr", {21'b0, par_addr}, 32'd0);
    chk("rst par_out", par_out, 32'd0);
    chk("rst par_req", {31'b0, par_req}, 32'd0);
    chk("rst par_we", {31'b0, par_we}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sel = 1'b0;

    // Write, ack 3 cycles into REQ, dropped one cycle later.
    run_access("wr", 1'b1, 11'h012, 32'hDEAD_BEEF, $urandom, 3, 4, -1);
    // Read with minimum wait: ack up from the first REQ cycle.
    run_access("rd_wmin", 1'b0, 11'h034, $urandom, 32'hCAFE_0001, 0, 3, -1);
    // Read timeout, ack never raised.
    run_access("rd_tmo", 1'b0, 11'h056, $urandom, $urandom, 100, 100, -1);
    // Next access proceeds normally, err remains set.
    run_access("after_tmo", 1'b1, 11'h057, $urandom, $urandom, 0, 3, -1);
    // Second timeout with err_clr on the very cycle err is set: set wins.
    run_access("tmo_clr", 0, 11'h058, $urandom, $urandom, 100, 100, TMO + 1);

    // err_clr on its own clears the flag.
    @(posedge clk); #1;
    sel     = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr alone", {31'b0, err}, 32'd0);
    err_model = 1'b0;

    // Write timeout to set err again, then reset in the middle of REQ.
    run_access("wr_tmo", 1'b1, 11'h1A5, $urandom, $urandom, 100, 100, -1);
    @(posedge clk); #1;
    sel     = 1'b1;
    we      = 1'b0;
    addr    = 11'h3FF;
    data_in = $urandom;
    par_ack = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst par_req", {31'b0, par_req}, 32'd1);
    chk("pre_rst err", {31'b0, err}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst par_req", {31'b0, par_req}, 32'd0);
    chk("mid_rst stall", {31'b0, stall}, 32'd0);
    chk("mid_rst err", {31'b0, err}, 32'd0);
    chk("mid_rst par_addr", {21'b0, par_addr}, 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    prev_addr  = '0;
    data_model = '0;
    err_model  = 1'b0;

    // Clean access after reset.
    run_access("post_rst", 1'b0, 11'h0AA, $urandom, $urandom, 1, 3, -1);

    // Back-to-back reads, ack up at once and dropped right after acceptance.
    run_access("b2b_1", 1'b0, 11'h001, $urandom, $urandom, 0, 3, -1);
    run_access("b2b_2", 1'b0, 11'h002, $urandom, $urandom, 0, 3, -1);

    // Randomized accesses.
    for (int i = 0; i < 24; i++) begin
      int r;
      int f;
      int cc;
      r  = $urandom_range(0, 10);
      f  = r + $urandom_range(0, 4);
      cc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_access("rand", 1'($urandom_range(0, 1)), 11'($urandom), $urandom, $urandom, r, f, cc);
    end

    @(posedge clk); #1;
    sel     = 1'b0;
    err_clr = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_xpar_bridge
`default_nettype wire
